// File: rtl/seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler
//   Time-multiplexes four hex digits onto a single shared 7-segment driver.
//   Enabled digits are scanned round-robin. Each digit slot is split into:
//     - a blanking gap, where all digits are off, so the previous digit does
//       not ghost onto the next one;
//     - a show phase.
//   New digit values arrive through a req/ack handshake. They are captured
//   into shadow registers only at a frame boundary, or while idle, so a frame
//   is never torn.
//
// Parameters
//   SCAN_DIV   in_clk cycles per digit slot (blank + show); must be > BLANK_CYC
//   BLANK_CYC  cycles per slot with all digits off; must be >= 1
//
// Ports
//   in_clk      in   system clock
//   rst         in   asynchronous active-low reset
//   digit_val   in   digit i value = digit_val[4i+3:4i]
//   dp_in       in   decimal point per digit
//   dig_en      in   digit enable mask, bit i = scan digit i
//   upd_req     in   request to load digit_val/dp_in/dig_en
//   upd_ack     out  1-cycle pulse: inputs were captured into the shadow
//   Seven_Seg   out  {dp,g,f,e,d,c,b,a}, active-high
//   digit       out  one-hot digit enable, active-high, 0 = all off
//   frame_done  out  1-cycle pulse after a scan frame completes
// ---------------------------------------------------------------------------
module seg_scan_scheduler #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        in_clk,
  input  logic        rst,
  input  logic [15:0] digit_val,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  dig_en,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [7:0]  Seven_Seg,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     cur_r, cur_s;
  logic [15:0]    val_r;
  logic [3:0]     dp_r;
  logic [3:0]     en_r;

  logic [2:0]     nxt_s;
  logic           boundary_s;
  logic           sample_s;
  logic [3:0]     eff_mask_s;
  logic [3:0]     dig_s;
  logic [7:0]     seg_s;

  // Hex digit to segment pattern, bits g..a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Lowest enabled index of a mask. A zero mask returns 0; callers check
  // for a zero mask separately.
  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] idx;
    if (m[0])      idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  // {found, idx}: the lowest enabled index strictly above cur.
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = 2'd0;
    // Scanning downwards leaves the lowest qualifying index in idx.
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(cur)) && m[i]) begin
        found = 1'b1;
        idx   = 2'(i);
      end
    end
    return {found, idx};
  endfunction

  // Next-state, slot selection and next registered output values.
  always_comb begin
    state_s    = state_r;
    cur_s      = cur_r;
    nxt_s      = next_above(en_r, cur_r);
    boundary_s = (state_r == SHOW) && (cnt_r == SHOW_LAST) && !nxt_s[2];
    sample_s   = upd_req && ((state_r == IDLE) || boundary_s);
    // At a boundary where a new mask is captured, the next frame follows that
    // new mask rather than the outgoing one.
    eff_mask_s = sample_s ? dig_en : en_r;

    case (state_r)
      IDLE: begin
        if (sample_s && (dig_en != 4'd0)) begin
          state_s = BLANK;
          cur_s   = lowest(dig_en);
        end else begin
          state_s = IDLE;
        end
      end
      BLANK: begin
        if (cnt_r == BLANK_LAST) state_s = SHOW;
        else                     state_s = BLANK;
      end
      SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          if (nxt_s[2]) begin
            state_s = BLANK;
            cur_s   = nxt_s[1:0];
          end else if (eff_mask_s == 4'd0) begin
            state_s = IDLE;
          end else begin
            state_s = BLANK;
            cur_s   = lowest(eff_mask_s);
          end
        end else begin
          state_s = SHOW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // The shadow registers never change on an edge that enters SHOW, so
    // their current contents are the values that will be displayed.
    if (state_s == SHOW) begin
      dig_s = 4'b0001 << cur_s;
      seg_s = {dp_r[cur_s], seg7(val_r[{cur_s, 2'b00} +: 4])};
    end else begin
      dig_s = 4'd0;
      seg_s = 8'd0;
    end
  end

  // State, slot counter, shadow registers and registered outputs.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      cur_r      <= 2'd0;
      val_r      <= 16'd0;
      dp_r       <= 4'd0;
      en_r       <= 4'd0;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
      digit      <= 4'd0;
      Seven_Seg  <= 8'd0;
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      // The counter restarts on every state change and holds at 0 while idle.
      if ((state_s != state_r) || (state_r == IDLE)) cnt_r <= '0;
      else                                           cnt_r <= cnt_r + 1'b1;
      if (sample_s) begin
        val_r <= digit_val;
        dp_r  <= dp_in;
        en_r  <= dig_en;
      end else begin
        val_r <= val_r;
        dp_r  <= dp_r;
        en_r  <= en_r;
      end
      upd_ack    <= sample_s;
      frame_done <= boundary_s;
      digit      <= dig_s;
      Seven_Seg  <= seg_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_scheduler
//   Table-driven bench for seg_scan_scheduler with SCAN_DIV=8 and BLANK_CYC=2.
//   Each table row drives the inputs for one clock edge and lists the outputs
//   expected after that edge. The reset sequences are written out by hand.
// ---------------------------------------------------------------------------
module tb_seg_scan_scheduler;

  logic        in_clk;
  logic        rst;
  logic [15:0] digit_val;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic        upd_req;
  logic        upd_ack;
  logic [7:0]  Seven_Seg;
  logic [3:0]  digit;
  logic        frame_done;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        req;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        ack;
    logic        fd;
    logic [3:0]  dig;
    logic [7:0]  seg;
  } row_t;

  row_t tbl[$];

  seg_scan_scheduler #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .in_clk     (in_clk),
    .rst        (rst),
    .digit_val  (digit_val),
    .dp_in      (dp_in),
    .dig_en     (dig_en),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .Seven_Seg  (Seven_Seg),
    .digit      (digit),
    .frame_done (frame_done)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic req, input logic [15:0] val, input logic [3:0] dp,
                     input logic [3:0] en, input logic ack, input logic fd,
                     input logic [3:0] dig, input logic [7:0] seg);
    row_t r;
    r.req = req; r.val = val; r.dp = dp; r.en = en;
    r.ack = ack; r.fd = fd; r.dig = dig; r.seg = seg;
    repeat (n) tbl.push_back(r);
  endtask

  // Called at a negedge: drive inputs, let one active edge pass, then check
  // the outputs on the following negedge.
  task automatic run_row(input row_t r, input int idx);
    upd_req   = r.req;
    digit_val = r.val;
    dp_in     = r.dp;
    dig_en    = r.en;
    @(posedge in_clk);
    @(negedge in_clk);
    chk("upd_ack",    idx, 32'(upd_ack),    32'(r.ack));
    chk("frame_done", idx, 32'(frame_done), 32'(r.fd));
    chk("digit",      idx, 32'(digit),      32'(r.dig));
    chk("Seven_Seg",  idx, 32'(Seven_Seg),  32'(r.seg));
  endtask

  task automatic chk_zero(input string tag, input int idx);
    chk({tag, "_ack"}, idx, 32'(upd_ack),    32'd0);
    chk({tag, "_fd"},  idx, 32'(frame_done), 32'd0);
    chk({tag, "_dig"}, idx, 32'(digit),      32'd0);
    chk({tag, "_seg"}, idx, 32'(Seven_Seg),  32'd0);
  endtask

  initial begin
    row_t r;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    upd_req   = 1'b0;
    digit_val = 16'd0;
    dp_in     = 4'd0;
    dig_en    = 4'd0;

    // Reset held while the inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge in_clk);
      upd_req   = ~upd_req;
      digit_val = 16'(32'h1234 * (i + 1));
      dp_in     = 4'(i + 5);
      dig_en    = 4'(i + 1);
      @(negedge in_clk);
      chk_zero("reset", i);
    end
    upd_req   = 1'b0;
    digit_val = 16'd0;
    dp_in     = 4'd0;
    dig_en    = 4'd0;
    rst       = 1'b1;

    // req, val, dp, en | ack, fd, digit, seg
    // Idle after reset release.
    add(2, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    // Single-digit load.
    add(1, 1'b1, 16'h0005, 4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1, 1'b0, 16'h0005, 4'h0, 4'h1, 1'b0, 1'b0, 4'h0, 8'h00);
    add(6, 1'b0, 16'h0005, 4'h0, 4'h1, 1'b0, 1'b0, 4'h1, 8'h6D);
    add(1, 1'b0, 16'h0005, 4'h0, 4'h1, 1'b0, 1'b1, 4'h0, 8'h00);
    add(1, 1'b0, 16'h0005, 4'h0, 4'h1, 1'b0, 1'b0, 4'h0, 8'h00);
    add(6, 1'b0, 16'h0005, 4'h0, 4'h1, 1'b0, 1'b0, 4'h1, 8'h6D);
    add(1, 1'b0, 16'h0005, 4'h0, 4'h1, 1'b0, 1'b1, 4'h0, 8'h00);
    // Skip pattern, requested mid-frame and taken at the boundary.
    add(1, 1'b1, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h0, 8'h00);
    add(6, 1'b1, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h1, 8'h6D);
    add(1, 1'b1, 16'hA0C0, 4'h8, 4'hA, 1'b1, 1'b1, 4'h0, 8'h00);
    add(1, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h0, 8'h00);
    add(6, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h2, 8'h39);
    add(2, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h0, 8'h00);
    add(6, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h8, 8'hF7);
    add(1, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b1, 4'h0, 8'h00);
    add(1, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1, 1'b0, 16'hA0C0, 4'h8, 4'hA, 1'b0, 1'b0, 4'h2, 8'h39);
    // Deferred update: old values persist until the boundary.
    add(5, 1'b1, 16'h1111, 4'h0, 4'h1, 1'b0, 1'b0, 4'h2, 8'h39);
    add(2, 1'b1, 16'h1111, 4'h0, 4'h1, 1'b0, 1'b0, 4'h0, 8'h00);
    add(6, 1'b1, 16'h1111, 4'h0, 4'h1, 1'b0, 1'b0, 4'h8, 8'hF7);
    add(1, 1'b1, 16'h1111, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0, 8'h00);
    add(1, 1'b0, 16'h1111, 4'h0, 4'h1, 1'b0, 1'b0, 4'h0, 8'h00);
    add(2, 1'b0, 16'h1111, 4'h0, 4'h1, 1'b0, 1'b0, 4'h1, 8'h06);
    // Zero mask: go idle at the boundary, then a later req is acked at once.
    add(4, 1'b1, 16'h1111, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 8'h06);
    add(1, 1'b1, 16'h1111, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 8'h00);
    add(2, 1'b0, 16'h1111, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
    add(1, 1'b1, 16'h0300, 4'h4, 4'h4, 1'b1, 1'b0, 4'h0, 8'h00);
    add(1, 1'b0, 16'h0300, 4'h4, 4'h4, 1'b0, 1'b0, 4'h0, 8'h00);
    add(2, 1'b0, 16'h0300, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 8'hCF);

    foreach (tbl[i]) run_row(tbl[i], i);

    // Reset during digit=0100: the outputs clear without waiting for a clock.
    #2 rst = 1'b0;
    #1 chk_zero("async_rst", 0);
    @(negedge in_clk);
    @(negedge in_clk);
    chk_zero("rst_hold", 0);
    rst = 1'b1;

    // No scan resumes until a new request arrives.
    r.req = 1'b0; r.val = 16'h0300; r.dp = 4'h4; r.en = 4'h4;
    r.ack = 1'b0; r.fd = 1'b0; r.dig = 4'h0; r.seg = 8'h00;
    for (int i = 0; i < 3; i++) run_row(r, 1000 + i);
    r.req = 1'b1; r.ack = 1'b1;
    run_row(r, 1003);
    r.req = 1'b0; r.ack = 1'b0;
    run_row(r, 1004);
    r.dig = 4'h4; r.seg = 8'hCF;
    run_row(r, 1005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
